// File: rtl/mini_mips_instr_sequencer.sv
// mini_mips_instr_sequencer
// Programmable instruction sequencer for the MiniMIPS core. A host loads a
// table of instructions with expected results; a run then issues the table
// either back-to-back or one entry per step pulse. The core result is
// sampled a fixed number of edges after each issue, compared with the
// stored expectation and tallied into pass/fail statistics.
module mini_mips_instr_sequencer #(
   parameter int                 INSTR_W   = 16,
   parameter int                 DATA_W    = 32,
   parameter int                 DEPTH     = 16,
   parameter int                 ADDR_W    = $clog2(DEPTH),
   parameter int                 RES_LAT   = 1,
   parameter logic [INSTR_W-1:0] NOP_INSTR = {INSTR_W{1'b0}}
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               prog_we_i,
   input  logic [ADDR_W-1:0]  prog_addr_i,
   input  logic [INSTR_W-1:0] prog_instr_i,
   input  logic [DATA_W-1:0]  prog_expect_i,
   input  logic               prog_check_i,
   input  logic [ADDR_W-1:0]  prog_last_i,
   input  logic               start_i,
   input  logic               step_mode_i,
   input  logic               step_i,
   input  logic               abort_i,
   input  logic [DATA_W-1:0]  result_i,
   output logic [INSTR_W-1:0] instruction_o,
   output logic               instr_valid_o,
   output logic               busy_o,
   output logic               done_o,
   output logic [ADDR_W:0]    pass_cnt_o,
   output logic [ADDR_W:0]    fail_cnt_o,
   output logic [ADDR_W-1:0]  first_fail_addr_o,
   output logic               first_fail_vld_o
);

   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W-1:0] PC_ONE  = ADDR_W'(1);

   typedef enum logic [2:0] {
      StIdle,
      StIssue,
      StStepWait,
      StDrain,
      StDone
   } state_t;

   state_t state_q, state_d;

   // program table; deliberately left without reset
   logic [INSTR_W-1:0] instrMem  [DEPTH];
   logic [DATA_W-1:0]  expectMem [DEPTH];
   logic [DEPTH-1:0]   checkMem;

   // run control
   logic [ADDR_W-1:0]  pc_q, pc_d;
   logic [ADDR_W-1:0]  last_q, last_d;
   logic               stepMode_q, stepMode_d;
   logic [INSTR_W-1:0] instr_q, instr_d;
   logic               instrValid_q, instrValid_d;

   // statistics
   logic [ADDR_W:0]    passCnt_q, passCnt_d;
   logic [ADDR_W:0]    failCnt_q, failCnt_d;
   logic [ADDR_W-1:0]  firstFailAddr_q, firstFailAddr_d;
   logic               firstFailVld_q, firstFailVld_d;

   // tag pipe: one slot per edge of result latency, oldest slot at RES_LAT-1
   logic [RES_LAT-1:0] tagValid_q, tagValid_d;
   logic [RES_LAT-1:0] tagCheck_q, tagCheck_d;
   logic [ADDR_W-1:0]  tagAddr_q [RES_LAT];
   logic [ADDR_W-1:0]  tagAddr_d [RES_LAT];

   // issue request from the FSM, consumed by the tag pipe and output regs
   logic               issue;
   logic [ADDR_W-1:0]  issueAddr;
   logic               flush;

   logic [ADDR_W-1:0]  pcInc;
   logic               resultDue;
   logic               resultMatch;
   logic               pipeEmpty;
   logic               progAllowed;

   assign pcInc       = pc_q + PC_ONE;
   assign resultDue   = tagValid_q[RES_LAT-1] & tagCheck_q[RES_LAT-1];
   assign resultMatch = (result_i == expectMem[tagAddr_q[RES_LAT-1]]);
   assign pipeEmpty   = (tagValid_q == '0);
   assign progAllowed = (state_q == StIdle) || (state_q == StDone);

   // table writes are only accepted while no run is in progress
   always_ff @(posedge clk) begin
      if (prog_we_i && progAllowed) begin
         instrMem[prog_addr_i]  <= prog_instr_i;
         expectMem[prog_addr_i] <= prog_expect_i;
         checkMem[prog_addr_i]  <= prog_check_i;
      end
   end

   // state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // next state, issue decision and statistics update
   always_comb begin
      state_d         = state_q;
      pc_d            = pc_q;
      last_d          = last_q;
      stepMode_d      = stepMode_q;
      instr_d         = NOP_INSTR;
      instrValid_d    = 1'b0;
      passCnt_d       = passCnt_q;
      failCnt_d       = failCnt_q;
      firstFailAddr_d = firstFailAddr_q;
      firstFailVld_d  = firstFailVld_q;
      issue           = 1'b0;
      issueAddr       = '0;
      flush           = 1'b0;

      if (resultDue) begin
         if (resultMatch) begin
            passCnt_d = passCnt_q + CNT_ONE;
         end else begin
            failCnt_d = failCnt_q + CNT_ONE;
            if (!firstFailVld_q) begin
               firstFailAddr_d = tagAddr_q[RES_LAT-1];
               firstFailVld_d  = 1'b1;
            end
         end
      end

      unique case (state_q)
         StIdle, StDone: begin
            if (start_i) begin
               last_d          = prog_last_i;
               stepMode_d      = step_mode_i;
               passCnt_d       = '0;
               failCnt_d       = '0;
               firstFailAddr_d = '0;
               firstFailVld_d  = 1'b0;
               issue           = 1'b1;
               issueAddr       = '0;
               state_d         = step_mode_i ? StStepWait : StIssue;
            end
         end
         StIssue: begin
            if (pc_q == last_q) begin
               state_d = StDrain;
            end else begin
               issue     = 1'b1;
               issueAddr = pcInc;
               if (stepMode_q) begin
                  state_d = StStepWait;
               end
            end
         end
         StStepWait: begin
            if (pc_q == last_q) begin
               state_d = StDrain;
            end else if (step_i) begin
               issue     = 1'b1;
               issueAddr = pcInc;
               if (pcInc == last_q) begin
                  state_d = StDrain;
               end
            end
         end
         StDrain: begin
            if (pipeEmpty) begin
               state_d = StDone;
            end
         end
         default: begin
            state_d = StIdle;
         end
      endcase

      if (issue) begin
         pc_d         = issueAddr;
         instr_d      = instrMem[issueAddr];
         instrValid_d = 1'b1;
      end

      if (abort_i) begin
         state_d         = StIdle;
         instr_d         = NOP_INSTR;
         instrValid_d    = 1'b0;
         issue           = 1'b0;
         flush           = 1'b1;
         pc_d            = pc_q;
         last_d          = last_q;
         stepMode_d      = stepMode_q;
         passCnt_d       = passCnt_q;
         failCnt_d       = failCnt_q;
         firstFailAddr_d = firstFailAddr_q;
         firstFailVld_d  = firstFailVld_q;
      end
   end

   // tag pipe shift: new issue enters slot 0, abort empties every slot
   always_comb begin
      tagValid_d = '0;
      tagCheck_d = '0;
      for (int i = 0; i < RES_LAT; i++) begin
         tagAddr_d[i] = '0;
      end
      if (!flush) begin
         tagValid_d[0] = issue;
         tagCheck_d[0] = checkMem[issueAddr];
         tagAddr_d[0]  = issueAddr;
         for (int i = 1; i < RES_LAT; i++) begin
            tagValid_d[i] = tagValid_q[i-1];
            tagCheck_d[i] = tagCheck_q[i-1];
            tagAddr_d[i]  = tagAddr_q[i-1];
         end
      end
   end

   // run control, output and statistics registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_q            <= '0;
         last_q          <= '0;
         stepMode_q      <= 1'b0;
         instr_q         <= NOP_INSTR;
         instrValid_q    <= 1'b0;
         passCnt_q       <= '0;
         failCnt_q       <= '0;
         firstFailAddr_q <= '0;
         firstFailVld_q  <= 1'b0;
      end else begin
         pc_q            <= pc_d;
         last_q          <= last_d;
         stepMode_q      <= stepMode_d;
         instr_q         <= instr_d;
         instrValid_q    <= instrValid_d;
         passCnt_q       <= passCnt_d;
         failCnt_q       <= failCnt_d;
         firstFailAddr_q <= firstFailAddr_d;
         firstFailVld_q  <= firstFailVld_d;
      end
   end

   // tag pipe registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tagValid_q <= '0;
         tagCheck_q <= '0;
         for (int i = 0; i < RES_LAT; i++) begin
            tagAddr_q[i] <= '0;
         end
      end else begin
         tagValid_q <= tagValid_d;
         tagCheck_q <= tagCheck_d;
         for (int i = 0; i < RES_LAT; i++) begin
            tagAddr_q[i] <= tagAddr_d[i];
         end
      end
   end

   assign instruction_o     = instr_q;
   assign instr_valid_o     = instrValid_q;
   assign busy_o            = (state_q == StIssue) || (state_q == StStepWait) ||
                              (state_q == StDrain);
   assign done_o            = (state_q == StDone);
   assign pass_cnt_o        = passCnt_q;
   assign fail_cnt_o        = failCnt_q;
   assign first_fail_addr_o = firstFailAddr_q;
   assign first_fail_vld_o  = firstFailVld_q;

endmodule

// File: tb/tb_mini_mips_instr_sequencer.sv
// tb_mini_mips_instr_sequencer
// Directed bench for the instruction sequencer. A stand-in core answers
// every instruction combinationally with {instr, ~instr}, which gives a
// one-edge result latency. A reference model tracks the program table, the
// list of entries a run must issue and the statistics those entries must
// produce; it is compared with the DUT at every falling edge.
module tb_mini_mips_instr_sequencer;

   localparam int INSTR_W = 16;
   localparam int DATA_W  = 32;
   localparam int DEPTH   = 16;
   localparam int ADDR_W  = 4;
   localparam int RES_LAT = 1;

   logic               clk = 1'b0;
   logic               rst_n;
   logic               prog_we_i;
   logic [ADDR_W-1:0]  prog_addr_i;
   logic [INSTR_W-1:0] prog_instr_i;
   logic [DATA_W-1:0]  prog_expect_i;
   logic               prog_check_i;
   logic [ADDR_W-1:0]  prog_last_i;
   logic               start_i;
   logic               step_mode_i;
   logic               step_i;
   logic               abort_i;
   logic [DATA_W-1:0]  result_i;
   logic [INSTR_W-1:0] instruction_o;
   logic               instr_valid_o;
   logic               busy_o;
   logic               done_o;
   logic [ADDR_W:0]    pass_cnt_o;
   logic [ADDR_W:0]    fail_cnt_o;
   logic [ADDR_W-1:0]  first_fail_addr_o;
   logic               first_fail_vld_o;

   int nChecks = 0;
   int nErrors = 0;

   // reference model state
   logic [INSTR_W-1:0] refInstr  [DEPTH];
   logic [DATA_W-1:0]  refExpect [DEPTH];
   bit                 refCheck  [DEPTH];
   int                 issueQ [$];
   int                 latQ [$];
   int                 mPass;
   int                 mFail;
   int                 mFfAddr;
   bit                 mFfVld;
   bit                 startSeen;
   bit                 abortSeen;
   int                 validTotal = 0;

   function automatic logic [DATA_W-1:0] coreFn(input logic [INSTR_W-1:0] ins);
      return {ins, ~ins};
   endfunction

   always #5 clk = ~clk;

   assign result_i = coreFn(instruction_o);

   mini_mips_instr_sequencer #(
      .INSTR_W (INSTR_W),
      .DATA_W  (DATA_W),
      .DEPTH   (DEPTH),
      .ADDR_W  (ADDR_W),
      .RES_LAT (RES_LAT)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .prog_we_i         (prog_we_i),
      .prog_addr_i       (prog_addr_i),
      .prog_instr_i      (prog_instr_i),
      .prog_expect_i     (prog_expect_i),
      .prog_check_i      (prog_check_i),
      .prog_last_i       (prog_last_i),
      .start_i           (start_i),
      .step_mode_i       (step_mode_i),
      .step_i            (step_i),
      .abort_i           (abort_i),
      .result_i          (result_i),
      .instruction_o     (instruction_o),
      .instr_valid_o     (instr_valid_o),
      .busy_o            (busy_o),
      .done_o            (done_o),
      .pass_cnt_o        (pass_cnt_o),
      .fail_cnt_o        (fail_cnt_o),
      .first_fail_addr_o (first_fail_addr_o),
      .first_fail_vld_o  (first_fail_vld_o)
   );

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, actual, expected);
      end
   endtask

   // per-cycle comparison against the reference model, run at the falling edge
   task automatic compareCycle();
      int a;
      if (!rst_n) begin
         issueQ.delete();
         latQ.delete();
         mPass = 0;
         mFail = 0;
         mFfAddr = 0;
         mFfVld = 1'b0;
         startSeen = 1'b0;
         abortSeen = 1'b0;
         return;
      end
      if (abortSeen) begin
         latQ.delete();
         issueQ.delete();
      end
      if (startSeen) begin
         mPass = 0;
         mFail = 0;
         mFfAddr = 0;
         mFfVld = 1'b0;
      end
      abortSeen = 1'b0;
      startSeen = 1'b0;
      if (latQ.size() >= RES_LAT) begin
         a = latQ.pop_front();
         if (a >= 0 && refCheck[a]) begin
            if (coreFn(refInstr[a]) == refExpect[a]) begin
               mPass++;
            end else begin
               mFail++;
               if (!mFfVld) begin
                  mFfVld = 1'b1;
                  mFfAddr = a;
               end
            end
         end
      end
      checkOutput("passCnt", 32'(pass_cnt_o), 32'(mPass));
      checkOutput("failCnt", 32'(fail_cnt_o), 32'(mFail));
      checkOutput("firstFailVld", 32'(first_fail_vld_o), 32'(mFfVld));
      if (mFfVld) begin
         checkOutput("firstFailAddr", 32'(first_fail_addr_o), 32'(mFfAddr));
      end
      if (instr_valid_o) begin
         validTotal++;
         if (issueQ.size() == 0) begin
            checkOutput("extraIssue", 32'(instr_valid_o), 32'd0);
            latQ.push_back(-1);
         end else begin
            a = issueQ.pop_front();
            checkOutput("issuedInstr", 32'(instruction_o), 32'(refInstr[a]));
            latQ.push_back(a);
         end
      end else begin
         checkOutput("idleInstrNop", 32'(instruction_o), 32'd0);
         latQ.push_back(-1);
      end
      if (abort_i) begin
         abortSeen = 1'b1;
      end else if (start_i && !busy_o) begin
         startSeen = 1'b1;
         issueQ.delete();
         for (int i = 0; i <= int'(prog_last_i); i++) begin
            issueQ.push_back(i);
         end
      end
   endtask

   // one clock: compare at the falling edge, then move just past the rising edge
   task automatic tick();
      @(negedge clk);
      compareCycle();
      @(posedge clk);
      #2;
   endtask

   task automatic applyStimulus(input bit doStart, input bit doStep, input bit doAbort);
      start_i = doStart;
      step_i  = doStep;
      abort_i = doAbort;
      tick();
      start_i = 1'b0;
      step_i  = 1'b0;
      abort_i = 1'b0;
   endtask

   task automatic progWrite(input int addr, input logic [INSTR_W-1:0] ins,
                            input logic [DATA_W-1:0] exp, input bit chk);
      prog_we_i     = 1'b1;
      prog_addr_i   = ADDR_W'(addr);
      prog_instr_i  = ins;
      prog_expect_i = exp;
      prog_check_i  = chk;
      if (!busy_o) begin
         refInstr[addr]  = ins;
         refExpect[addr] = exp;
         refCheck[addr]  = chk;
      end
      tick();
      prog_we_i = 1'b0;
   endtask

   task automatic pulseStart(input int last, input bit stepMode);
      prog_last_i = ADDR_W'(last);
      step_mode_i = stepMode;
      applyStimulus(1'b1, 1'b0, 1'b0);
   endtask

   task automatic waitDone(input int maxCycles, output int n);
      n = 0;
      while (!done_o && n < maxCycles) begin
         tick();
         n++;
      end
      checkOutput("doneReached", 32'(done_o), 32'd1);
   endtask

   initial begin
      int n;
      int base;
      logic [INSTR_W-1:0] t2 [4];
      t2[0] = 16'h0761;
      t2[1] = 16'h0762;
      t2[2] = 16'h0764;
      t2[3] = 16'h0763;

      rst_n = 1'b0;
      prog_we_i = 1'b0;
      prog_addr_i = '0;
      prog_instr_i = '0;
      prog_expect_i = '0;
      prog_check_i = 1'b0;
      prog_last_i = '0;
      start_i = 1'b0;
      step_mode_i = 1'b0;
      step_i = 1'b0;
      abort_i = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
         refInstr[i] = '0;
         refExpect[i] = '0;
         refCheck[i] = 1'b0;
      end

      #12;
      checkOutput("rstInstruction", 32'(instruction_o), 32'd0);
      checkOutput("rstValid", 32'(instr_valid_o), 32'd0);
      checkOutput("rstBusy", 32'(busy_o), 32'd0);
      checkOutput("rstDone", 32'(done_o), 32'd0);
      rst_n = 1'b1;
      tick();

      // T1: asynchronous reset in the middle of a run
      for (int i = 0; i < 4; i++) progWrite(i, t2[i], coreFn(t2[i]), 1'b1);
      for (int i = 4; i < 8; i++) progWrite(i, 16'h0761 + 16'(i), coreFn(16'h0761 + 16'(i)), 1'b1);
      pulseStart(7, 1'b0);
      repeat (3) tick();
      checkOutput("t1PassBeforeReset", 32'(pass_cnt_o), 32'd3);
      checkOutput("t1BusyBeforeReset", 32'(busy_o), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("t1Instruction", 32'(instruction_o), 32'd0);
      checkOutput("t1Valid", 32'(instr_valid_o), 32'd0);
      checkOutput("t1Busy", 32'(busy_o), 32'd0);
      checkOutput("t1Done", 32'(done_o), 32'd0);
      checkOutput("t1Pass", 32'(pass_cnt_o), 32'd0);
      checkOutput("t1Fail", 32'(fail_cnt_o), 32'd0);
      checkOutput("t1FfAddr", 32'(first_fail_addr_o), 32'd0);
      checkOutput("t1FfVld", 32'(first_fail_vld_o), 32'd0);
      tick();
      rst_n = 1'b1;
      tick();
      checkOutput("t1IdleBusy", 32'(busy_o), 32'd0);
      checkOutput("t1IdleValid", 32'(instr_valid_o), 32'd0);

      // T2: four back-to-back issues, all matching
      base = validTotal;
      pulseStart(3, 1'b0);
      waitDone(20, n);
      checkOutput("t2DoneLatency", 32'(n), 32'd5);
      checkOutput("t2Pass", 32'(pass_cnt_o), 32'd4);
      checkOutput("t2Fail", 32'(fail_cnt_o), 32'd0);
      checkOutput("t2Issues", 32'(validTotal - base), 32'd4);
      checkOutput("t2AllIssued", 32'(issueQ.size()), 32'd0);

      // T3: entries 2 and 3 carry wrong expectations
      progWrite(2, t2[2], coreFn(t2[2]) ^ 32'h1, 1'b1);
      progWrite(3, t2[3], coreFn(t2[3]) ^ 32'h1, 1'b1);
      pulseStart(3, 1'b0);
      waitDone(20, n);
      checkOutput("t3Pass", 32'(pass_cnt_o), 32'd2);
      checkOutput("t3Fail", 32'(fail_cnt_o), 32'd2);
      checkOutput("t3FfAddr", 32'(first_fail_addr_o), 32'd2);
      checkOutput("t3FfVld", 32'(first_fail_vld_o), 32'd1);

      // T4: single-step run over entries 0 and 1
      base = validTotal;
      pulseStart(1, 1'b1);
      repeat (10) tick();
      checkOutput("t4OneIssueBeforeStep", 32'(validTotal - base), 32'd1);
      checkOutput("t4BusyWaiting", 32'(busy_o), 32'd1);
      checkOutput("t4WaitInstrNop", 32'(instruction_o), 32'd0);
      applyStimulus(1'b0, 1'b1, 1'b0);
      checkOutput("t4StepInstr", 32'(instruction_o), 32'h0762);
      checkOutput("t4DoneEarly0", 32'(done_o), 32'd0);
      tick();
      checkOutput("t4DoneEarly1", 32'(done_o), 32'd0);
      tick();
      checkOutput("t4Done", 32'(done_o), 32'd1);
      checkOutput("t4Issues", 32'(validTotal - base), 32'd2);
      checkOutput("t4Pass", 32'(pass_cnt_o), 32'd2);
      applyStimulus(1'b0, 1'b1, 1'b0);
      tick();
      checkOutput("t4StepIgnored", 32'(validTotal - base), 32'd2);

      // T5: abort with entry 2 on the bus, then restart
      progWrite(2, t2[2], coreFn(t2[2]), 1'b1);
      progWrite(3, t2[3], coreFn(t2[3]), 1'b1);
      pulseStart(3, 1'b0);
      repeat (2) tick();
      applyStimulus(1'b0, 1'b0, 1'b1);
      checkOutput("t5Busy", 32'(busy_o), 32'd0);
      checkOutput("t5Done", 32'(done_o), 32'd0);
      checkOutput("t5Valid", 32'(instr_valid_o), 32'd0);
      checkOutput("t5PassHeld", 32'(pass_cnt_o), 32'd2);
      repeat (2) tick();
      checkOutput("t5PassStillHeld", 32'(pass_cnt_o), 32'd2);
      pulseStart(3, 1'b0);
      waitDone(20, n);
      checkOutput("t5RestartPass", 32'(pass_cnt_o), 32'd4);
      checkOutput("t5RestartFail", 32'(fail_cnt_o), 32'd0);
      base = validTotal;
      applyStimulus(1'b1, 1'b0, 1'b1);
      checkOutput("t5AbortBeatsStartDone", 32'(done_o), 32'd0);
      checkOutput("t5AbortBeatsStartBusy", 32'(busy_o), 32'd0);
      tick();
      checkOutput("t5AbortBeatsStartIssues", 32'(validTotal - base), 32'd0);

      // T6: full table, unchecked entry, writes and start while busy
      for (int i = 0; i < DEPTH; i++) begin
         if (i == 4) progWrite(i, 16'h1000 + 16'(i * 16'h0101), 32'hDEAD_BEEF, 1'b0);
         else progWrite(i, 16'h1000 + 16'(i * 16'h0101), coreFn(16'h1000 + 16'(i * 16'h0101)), 1'b1);
      end
      base = validTotal;
      pulseStart(DEPTH - 1, 1'b0);
      tick();
      progWrite(5, 16'hFFFF, 32'h0, 1'b1);
      prog_last_i = 4'd2;
      applyStimulus(1'b1, 1'b0, 1'b0);
      waitDone(40, n);
      checkOutput("t6Issues", 32'(validTotal - base), 32'd16);
      checkOutput("t6Pass", 32'(pass_cnt_o), 32'd15);
      checkOutput("t6Fail", 32'(fail_cnt_o), 32'd0);
      checkOutput("t6FfVld", 32'(first_fail_vld_o), 32'd0);
      checkOutput("t6AllIssued", 32'(issueQ.size()), 32'd0);
      tick();

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
